data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Word-organised data memory that services the core's data bus from the memory side. It accepts level-held read and write requests from the MEM stage, waits a configurable number of cycles, then answers with a one-cycle `data_memory_response` pulse and registered read data. The MEM stage performs all sub-word and unaligned handling through aligned read-modify-write sequences, so this block only ever moves full 32-bit words.

## Interface
Parameters:
- `MEM_WORDS`, default 1024: depth in 32-bit words; must be a power of two; `IDX_W = $clog2(MEM_WORDS)`.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be aligned to 4·MEM_WORDS.
- `LATENCY`, default 1: request-sample to response, in cycles; legal range 1..15.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `data_memory_read` input 1: read request, held high until response.
- `data_memory_write` input 1: write request, held high until response.
- `data_address` input 32: byte address; bits [1:0] ignored.
- `write_data` input 32: full word to store.
- `read_data` output 32: registered read word; stable from the response cycle until the next response.
- `data_memory_response` output 1: one-cycle completion pulse.
- `bus_error_o` output 1: one-cycle pulse coincident with the response for an illegal access.

## Operation
- States: IDLE, WAIT, RESPOND.
- IDLE: if read or write is high, latch the request:
  - address, write_data, kind (write when `data_memory_write` is high), and `lat_cnt = LATENCY-1`.
  - Go to RESPOND if LATENCY==1, otherwise to WAIT.
- WAIT: decrement `lat_cnt` each cycle.
  - If the latched request kind's line drops, abort to IDLE: no response, no write commit.
  - When `lat_cnt` reaches 0, go to RESPOND.
- Leaving for RESPOND (the IDLE→RESPOND or WAIT→RESPOND edge):
  - Write: `mem[idx] <= latched data`.
  - Read: `read_data <= mem[idx]`.
- RESPOND: `data_memory_response=1`, then unconditionally go to IDLE.
  - The request is not sampled in RESPOND, because the initiator still holds the old request during the response cycle.
- Index: `idx = (latched_address - BASE_ADDR)[IDX_W+1:2]`.
- Read and write both high in IDLE: treated as a write; `bus_error_o` pulses with the response.
- Write data is committed exactly once per response. A new request seen in the IDLE cycle after RESPOND starts a new transaction, which allows back-to-back word accesses.
- Reset (any state): state→IDLE, `read_data=0`, `data_memory_response=0`, `bus_error_o=0`, `lat_cnt=0`. Array contents are not cleared. An in-flight write is not committed.

## Timing
- Request first seen high in IDLE at cycle 0 → response in cycle LATENCY.
- Read data is valid in the same cycle as the response and is held until the next response.
- Throughput: one transaction per LATENCY+1 cycles.
- The write is visible to a read issued in the cycle after its response.
- The array is synchronous: a single read/write port, registered output.

## Configuration
- `DATA_MEM_RANGE_CHECK_EN` defined:
  - An address outside [BASE_ADDR, BASE_ADDR+4·MEM_WORDS) still receives a normal response, with `bus_error_o=1`.
  - Out-of-range write: dropped.
  - Out-of-range read: `read_data=32'h0000_0000`.
- Not defined:
  - No check; the index wraps modulo MEM_WORDS.
  - `bus_error_o` pulses only for simultaneous read+write.

## Test plan
- LATENCY=1: write 0x0000_0010 ← 32'hCAFE_F00D, then read 0x0000_0010 → response in cycle 1 of each transaction; read_data=32'hCAFE_F00D.
- LATENCY=3: read 0x0000_0008 held high; address changes to 0x0000_000C in the cycle after the response → responses at cycles 3 and 7, with the two stored words returned in order.
- Write with LATENCY=4 to 0x0000_0020; drop the write in cycle 2; then read 0x0000_0020 → no response to the write; the old word is returned.
- Read and write both high, address 0x4 ← 32'h1234_5678 → write commits; response with bus_error_o=1.
- With RANGE_CHECK: MEM_WORDS=1024, read 0x0000_1000 → response, bus_error_o=1, read_data=0. Without the macro: the read returns mem[0].
- rst_n low during WAIT of a write → no response; the array word is unchanged; outputs are 0 next cycle.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder
// Word-organised data memory on the memory side of the core's data bus.
// Level-held read/write requests are accepted in IDLE, delayed by LATENCY
// cycles, then answered with a one-cycle data_memory_response pulse and a
// registered read word. Only aligned 32-bit words are moved; address bits
// [1:0] are ignored.
//
// Optional feature macro: DATA_MEM_RANGE_CHECK_EN
//   defined   : addresses outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) still
//               get a normal response, with bus_error_o set. Out-of-range
//               writes are dropped and out-of-range reads return zero.
//   undefined : no range check; the word index wraps modulo MEM_WORDS and
//               bus_error_o flags only simultaneous read+write requests.
//
// Parameter legality: MEM_WORDS is a power of two (>= 2), BASE_ADDR is
// aligned to 4*MEM_WORDS, and LATENCY is in 1..15.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a request; latches address, data and kind
// S_WAIT    | counting down lat_cnt; aborts if the request line drops
// S_RESPOND | response pulse cycle; the still-held request is not sampled

module data_memory_responder #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned LATENCY   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_memory_read,
   input  logic        data_memory_write,
   input  logic [31:0] data_address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        data_memory_response,
   output logic        bus_error_o
);

   localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
   localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);
   localparam bit          LAT_ONE  = (LATENCY == 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  lat_cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        is_write_q;
   logic        both_q;

   logic [31:0] mem [MEM_WORDS];

   logic             req_any;
   logic             abort;
   logic [31:0]      addr_sel;
   logic [31:0]      wdata_sel;
   logic             write_sel;
   logic             both_sel;
   logic [31:0]      offset;
   logic [IDX_W-1:0] idx;
   logic             out_of_range;
   logic             commit;

   // Request fields seen on the commit edge: live inputs when going straight
   // from IDLE to RESPOND, the latched copies when leaving WAIT.
   always_comb begin
      req_any = data_memory_read | data_memory_write;
      abort   = is_write_q ? ~data_memory_write : ~data_memory_read;
      if (state == S_IDLE) begin
         addr_sel  = data_address;
         wdata_sel = write_data;
         write_sel = data_memory_write;
         both_sel  = data_memory_read & data_memory_write;
      end else begin
         addr_sel  = addr_q;
         wdata_sel = wdata_q;
         write_sel = is_write_q;
         both_sel  = both_q;
      end
      offset = addr_sel - BASE_ADDR;
      idx    = offset[IDX_W+1:2];
      commit = ((state == S_IDLE) && req_any && LAT_ONE) ||
               ((state == S_WAIT) && !abort && (lat_cnt == 4'd1));
   end

`ifdef DATA_MEM_RANGE_CHECK_EN
   // Anything at or above 4*MEM_WORDS bytes past the base is outside the array.
   logic unused_offset_lsb;
   assign out_of_range      = (offset >> (IDX_W + 2)) != 32'd0;
   assign unused_offset_lsb = ^offset[1:0];
`else
   // Without the check the upper offset bits are simply discarded (wrap).
   logic unused_offset_bits;
   assign out_of_range       = 1'b0;
   assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};
`endif

   // Single-port array with registered read word; updated only on the commit edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         read_data <= '0;
      end else if (commit) begin
         if (write_sel) begin
            if (!out_of_range) begin
               mem[idx] <= wdata_sel;
            end
         end else begin
            read_data <= out_of_range ? 32'h0000_0000 : mem[idx];
         end
      end
   end

   // Transaction sequencer with registered response and error pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                <= S_IDLE;
         lat_cnt              <= '0;
         addr_q               <= '0;
         wdata_q              <= '0;
         is_write_q           <= 1'b0;
         both_q               <= 1'b0;
         data_memory_response <= 1'b0;
         bus_error_o          <= 1'b0;
      end else begin
         data_memory_response <= 1'b0;
         bus_error_o          <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_any) begin
                  addr_q     <= data_address;
                  wdata_q    <= write_data;
                  is_write_q <= data_memory_write;
                  both_q     <= data_memory_read & data_memory_write;
                  lat_cnt    <= LAT_INIT;
                  if (commit) begin
                     state                <= S_RESPOND;
                     data_memory_response <= 1'b1;
                     bus_error_o          <= both_sel | out_of_range;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (abort) begin
                  state   <= S_IDLE;
                  lat_cnt <= '0;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
                  if (commit) begin
                     state                <= S_RESPOND;
                     data_memory_response <= 1'b1;
                     bus_error_o          <= both_sel | out_of_range;
                  end
               end
            end
            S_RESPOND: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances (LATENCY 1, 3 and 4)
// driven one at a time. Directed table vectors, two hand-written sequences
// (aborted write, reset during WAIT) and random traffic against a word-array
// reference model. Honors DATA_MEM_RANGE_CHECK_EN when defined.

module tb_data_memory_responder;

   localparam int NDUT = 3;
   localparam int L0 = 1;
   localparam int L1 = 3;
   localparam int L2 = 4;
   localparam int MEMW = 1024;
   localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef DATA_MEM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        rd    [NDUT];
   logic        wr    [NDUT];
   logic [31:0] addr  [NDUT];
   logic [31:0] wdat  [NDUT];
   logic [31:0] rdata [NDUT];
   logic        resp  [NDUT];
   logic        err   [NDUT];

   int vectors;
   int miscompares;

   data_memory_responder #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE), .LATENCY(L0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .data_memory_read(rd[0]), .data_memory_write(wr[0]),
      .data_address(addr[0]), .write_data(wdat[0]),
      .read_data(rdata[0]), .data_memory_response(resp[0]), .bus_error_o(err[0]));

   data_memory_responder #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE), .LATENCY(L1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .data_memory_read(rd[1]), .data_memory_write(wr[1]),
      .data_address(addr[1]), .write_data(wdat[1]),
      .read_data(rdata[1]), .data_memory_response(resp[1]), .bus_error_o(err[1]));

   data_memory_responder #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE), .LATENCY(L2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .data_memory_read(rd[2]), .data_memory_write(wr[2]),
      .data_address(addr[2]), .write_data(wdat[2]),
      .read_data(rdata[2]), .data_memory_response(resp[2]), .bus_error_o(err[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [31:0] m_mem   [NDUT][MEMW];
   bit          m_known [NDUT][MEMW];
   logic [31:0] m_rd    [NDUT];
   bit          m_rd_ok [NDUT];

   function automatic int lat_of(input int d);
      case (d)
         0:       return L0;
         1:       return L1;
         default: return L2;
      endcase
   endfunction

   task automatic model_txn(input int d, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] wd,
                            output bit dk, output logic [31:0] erd, output logic eerr);
      logic [31:0] off;
      int          wi;
      bit          blocked;
      off     = a - BASE;
      wi      = int'((off / 4) % MEMW);
      blocked = RC && (off >= 32'(4 * MEMW));
      eerr    = (r && w) || blocked;
      if (w) begin
         if (!blocked) begin
            m_mem[d][wi]   = wd;
            m_known[d][wi] = 1'b1;
         end
      end else if (blocked) begin
         m_rd[d]    = 32'h0;
         m_rd_ok[d] = 1'b1;
      end else begin
         m_rd[d]    = m_mem[d][wi];
         m_rd_ok[d] = m_known[d][wi];
      end
      dk  = m_rd_ok[d];
      erd = m_rd[d];
   endtask

   // ---------------- checkers ----------------
   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, required %b", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   // Called mid-cycle while DUT d is in IDLE: that cycle is cycle 0.
   task automatic run_txn(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit dk, input logic [31:0] erd, input logic eerr,
                          input string tag);
      int n;
      bit got;
      for (int e = 0; e < NDUT; e++) begin
         if (e != d) begin
            rd[e] = 1'b0;
            wr[e] = 1'b0;
         end
      end
      rd[d] = r; wr[d] = w; addr[d] = a; wdat[d] = wd;
      n = 0;
      got = 1'b0;
      while (!got && n < lat_of(d) + 4) begin
         @(posedge clk); #1;
         n++;
         if (resp[d] === 1'b1) got = 1'b1;
      end
      vectors++;
      chk_int({tag, " latency"}, got ? n : -1, lat_of(d));
      if (got) begin
         if (dk) chk32({tag, " read_data"}, rdata[d], erd);
         chk1({tag, " bus_error"}, err[d], eerr);
         @(posedge clk); #1;
         chk1({tag, " pulse_end"}, resp[d], 1'b0);
         chk1({tag, " err_end"}, err[d], 1'b0);
         if (dk) chk32({tag, " read_hold"}, rdata[d], erd);
      end
   endtask

   task automatic idle_all();
      for (int e = 0; e < NDUT; e++) begin
         rd[e] = 1'b0;
         wr[e] = 1'b0;
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      int          d;
      logic        r;
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   localparam int NVEC = 12;
   vec_t tbl [NVEC];

   initial begin
      bit          dk;
      logic [31:0] erd;
      logic        eerr;
      logic [31:0] pool [8];
      int          resp_seen;

      vectors = 0;
      miscompares = 0;
      for (int e = 0; e < NDUT; e++) begin
         rd[e] = 1'b0; wr[e] = 1'b0; addr[e] = '0; wdat[e] = '0;
         m_rd[e] = 32'h0; m_rd_ok[e] = 1'b1;
      end

      tbl[0]  = '{0, 1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      tbl[1]  = '{0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0};
      tbl[2]  = '{0, 1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'hCAFE_F00D, 1'b1};
      tbl[3]  = '{0, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0};
      tbl[4]  = '{0, 1'b0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
      tbl[5]  = '{0, 1'b1, 1'b0, 32'h0000_1000, 32'h0,
                  RC ? 32'h0000_0000 : 32'hDEAD_BEEF, RC};
      tbl[6]  = '{1, 1'b0, 1'b1, 32'h0000_0008, 32'h1111_2222, 32'h0000_0000, 1'b0};
      tbl[7]  = '{1, 1'b0, 1'b1, 32'h0000_000C, 32'h3333_4444, 32'h0000_0000, 1'b0};
      tbl[8]  = '{1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1111_2222, 1'b0};
      tbl[9]  = '{1, 1'b1, 1'b0, 32'h0000_000C, 32'h0,         32'h3333_4444, 1'b0};
      tbl[10] = '{2, 1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_0001, 32'h0000_0000, 1'b0};
      tbl[11] = '{2, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'hA5A5_0001, 1'b0};

      // reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int e = 0; e < NDUT; e++) begin
         chk1($sformatf("reset resp%0d", e), resp[e], 1'b0);
         chk1($sformatf("reset err%0d", e), err[e], 1'b0);
         chk32($sformatf("reset rdata%0d", e), rdata[e], 32'h0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         model_txn(tbl[i].d, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, dk, erd, eerr);
         run_txn(tbl[i].d, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd,
                 1'b1, tbl[i].exp_rd, tbl[i].exp_err, $sformatf("vec%0d", i));
      end
      idle_all();
      @(posedge clk); #1;

      // aborted write on the LATENCY=4 instance: line dropped in cycle 2
      wr[2] = 1'b1; addr[2] = 32'h0000_0020; wdat[2] = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      resp_seen = (resp[2] === 1'b1) ? 1 : 0;
      @(posedge clk); #1;
      if (resp[2] === 1'b1) resp_seen++;
      wr[2] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (resp[2] === 1'b1) resp_seen++;
      end
      vectors++;
      chk_int("abort no_response", resp_seen, 0);
      model_txn(2, 1'b1, 1'b0, 32'h0000_0020, 32'h0, dk, erd, eerr);
      run_txn(2, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'hA5A5_0001, 1'b0, "abort readback");
      idle_all();
      @(posedge clk); #1;

      // reset while a LATENCY=4 write is in WAIT
      wr[2] = 1'b1; addr[2] = 32'h0000_0020; wdat[2] = 32'h0BAD_0BAD;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wr[2] = 1'b0;
      vectors++;
      for (int e = 0; e < NDUT; e++) begin
         chk1($sformatf("rstwait resp%0d", e), resp[e], 1'b0);
         chk1($sformatf("rstwait err%0d", e), err[e], 1'b0);
         chk32($sformatf("rstwait rdata%0d", e), rdata[e], 32'h0);
         m_rd[e] = 32'h0;
         m_rd_ok[e] = 1'b1;
      end
      resp_seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (resp[2] === 1'b1) resp_seen++;
      end
      chk_int("rstwait no_response", resp_seen, 0);
      model_txn(2, 1'b1, 1'b0, 32'h0000_0020, 32'h0, dk, erd, eerr);
      run_txn(2, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'hA5A5_0001, 1'b0, "rstwait readback");
      idle_all();
      @(posedge clk); #1;

      // random traffic against the model
      for (int d = 0; d < NDUT; d++) begin
         for (int p = 0; p < 8; p++) begin
            pool[p] = 32'($urandom_range(0, MEMW - 1)) << 2;
            model_txn(d, 1'b0, 1'b1, pool[p], $urandom(), dk, erd, eerr);
            run_txn(d, 1'b0, 1'b1, pool[p], m_mem[d][pool[p] >> 2], dk, erd, eerr,
                    $sformatf("fill d%0d p%0d", d, p));
         end
         for (int t = 0; t < 40; t++) begin
            logic        r, w;
            logic [31:0] a, wd;
            int          k;
            k  = int'($urandom_range(0, 9));
            r  = (k < 4) || (k >= 8);
            w  = (k >= 4);
            a  = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 6) == 0) a = a + 32'h0000_1000;
            wd = $urandom();
            model_txn(d, r, w, a, wd, dk, erd, eerr);
            run_txn(d, r, w, a, wd, dk, erd, eerr, $sformatf("rand d%0d t%0d", d, t));
            if ($urandom_range(0, 3) == 0) begin
               idle_all();
               @(posedge clk); #1;
            end
         end
         idle_all();
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
